mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//  Sits directly upstream of the 4-lane MAC controller in the fully-connected
//  layer datapath. Walks the neurons of one layer and reads feature, weight and
//  bias words from synchronous RAMs. Issues flush, feed and bias-add commands to
//  the MAC stage, collecting four neuron sums per group. Writes each packed
//  8-bit result word to output RAM and pulses done when the layer is complete.
// PARAMETERS
//  IN_LEN       784  number of 8-bit inputs per neuron
//  NUM_NEURONS  64   neurons in the layer, >=1 (need not be a multiple of 4)
//  ADDR_W       16   width of every RAM address port
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous active-high reset
//  start         in   1   1-cycle pulse: begin layer (ignored while busy)
//  abort         in   1   synchronous: return to IDLE next cycle, no further RAM writes
//  relu_in       in   1   ReLU select, latched on start
//  feat_addr     out  ADDR_W  feature RAM address (1-cycle read latency)
//  wght_addr     out  ADDR_W  weight RAM address (1-cycle read latency)
//  bias_addr     out  ADDR_W  bias RAM address (1-cycle read latency)
//  mac_en        out  1   1-cycle command strobe to MAC stage
//  mac_flush     out  1   command qualifier: clear accumulator
//  mac_valid     out  4   command qualifier: lane-valid mask for feed
//  mac_bias_add  out  1   command qualifier: add bias, load result buffers
//  mac_relu      out  1   latched ReLU select
//  mac_done      in   1   command acknowledge from MAC stage
//  mac_sum       in   26  signed accumulated neuron sum from MAC stage
//  result0..3    out  26  signed captured sums; slot j = neuron 4g+j
//  mac_data      in   32  packed 8-bit results from MAC stage
//  out_wr_en     out  1   output RAM write strobe
//  out_wr_addr   out  ADDR_W  output RAM address = group index g
//  out_wr_data   out  32  mac_data registered on the write cycle
//  busy          out  1   high from the cycle after start until done
//  done          out  1   1-cycle pulse: layer finished
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; reset mid-layer discards all progress.
//  IN_WORDS=ceil(IN_LEN/4); lane i = bits[8i+7:8i].
//  Last word valid mask = 4'b1111 if IN_LEN%4==0, else (1<<(IN_LEN%4))-1.
//  Counters: k word 0..IN_WORDS-1; n neuron 0..NUM_NEURONS-1; j=n%4; g=n/4.
//  Addresses: feat_addr=k, wght_addr=n*IN_WORDS+k, bias_addr=g.
//  Commands: mac_en high exactly 1 cycle with one qualifier; qualifiers 0 otherwise.
//  After a command, FSM waits in a WAIT state until mac_done=1 (no timeout).
//  mac_done is ignored in every non-WAIT state.
//  FSM:
//   IDLE  : start -> CLR; latch relu_in; busy=1; n=0; result0..3=0
//   CLR   : mac_en+mac_flush -> W_CLR -> (ack) FETCH, k=0
//   FETCH : drive addrs 1 cycle -> FEED
//   FEED  : mac_en+mac_valid (mask) -> W_FEED -> (ack) k==last ? CAPT : FETCH, k+1
//   CAPT  : result[j]<=mac_sum
//           -> (j==3 or n==last) ? BFETCH : CLR, n+1
//   BFETCH: bias_addr=g 1 cycle -> BIAS
//   BIAS  : mac_en+mac_bias_add -> W_BIAS -> (ack) SETTLE
//   SETTLE: 1 cycle for MAC result buffers -> WRITE
//   WRITE : out_wr_en=1 1 cycle, addr=g
//           -> n==last ? DONE : clear result0..3, n+1, CLR
//   DONE  : done=1 1 cycle, busy=0 -> IDLE
//  Partial last group: unused slots stay 0 before BIAS (their output = bias only).
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins.
//  abort in any state: next cycle IDLE, mac_en=0, out_wr_en=0, busy=0, no done pulse.
//  abort during WRITE: that write still completes.
//  Address arithmetic wraps modulo 2^ADDR_W; no saturation.
// TESTING
//  IN_LEN=8, NUM_NEURONS=4, ack 1 cycle after each cmd -> 1 CLR, 2 FEED (mask 1111)
//   per neuron, 1 BIAS, 1 write to addr 0, done once, busy low after done.
//  IN_LEN=6 -> 2nd feed of each neuron has mac_valid=4'b0011.
//  NUM_NEURONS=5 -> writes to addr 0 and 1; group 1 has result1..3=0 at BIAS.
//  ack delayed 5 cycles, mac_sum=26'h3FFFF00 at CAPT -> result0=-256; no command
//   reissued while waiting.
//  abort asserted during W_FEED of neuron 2 -> IDLE next cycle, no out_wr_en, no done;
//   a following start runs the full layer correctly.
//  rst asserted mid-BIAS -> all outputs 0 same cycle; start pulse while busy is ignored.

Source files
------------

// File: rtl/mac_sequencer.sv
// Layer sequencer for the 4-lane MAC stage: walks neurons and input words,
// issues flush/feed/bias commands and writes one packed result word per group.
module mac_sequencer #(
    parameter int IN_LEN      = 784,
    parameter int NUM_NEURONS = 64,
    parameter int ADDR_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_relu_in,
    output logic [ADDR_W-1:0] o_feat_addr,
    output logic [ADDR_W-1:0] o_wght_addr,
    output logic [ADDR_W-1:0] o_bias_addr,
    output logic              o_mac_en,
    output logic              o_mac_flush,
    output logic [3:0]        o_mac_valid,
    output logic              o_mac_bias_add,
    output logic              o_mac_relu,
    input  logic              i_mac_done,
    input  logic [25:0]       i_mac_sum,
    output logic [25:0]       o_result0,
    output logic [25:0]       o_result1,
    output logic [25:0]       o_result2,
    output logic [25:0]       o_result3,
    input  logic [31:0]       i_mac_data,
    output logic              o_out_wr_en,
    output logic [ADDR_W-1:0] o_out_wr_addr,
    output logic [31:0]       o_out_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IN_WORDS = (IN_LEN + 3) / 4;
    localparam int IN_REM   = IN_LEN % 4;
    localparam logic [3:0] LAST_MASK = (IN_REM == 0) ? 4'b1111 : 4'((1 << IN_REM) - 1);
    localparam int K_W = (IN_WORDS < 2) ? 1 : $clog2(IN_WORDS);
    localparam int N_W = (NUM_NEURONS <= 4) ? 2 : $clog2(NUM_NEURONS);
    localparam logic [K_W-1:0] K_LAST = K_W'(IN_WORDS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NUM_NEURONS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_W_CLR,
        S_FETCH,
        S_FEED,
        S_W_FEED,
        S_CAPT,
        S_BFETCH,
        S_BIAS,
        S_W_BIAS,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [K_W-1:0]   r_k;
    logic [N_W-1:0]   r_n;
    logic             r_relu;
    logic [25:0]      r_result0;
    logic [25:0]      r_result1;
    logic [25:0]      r_result2;
    logic [25:0]      r_result3;
    logic [31:0]      r_wr_data;
    logic             w_k_last;
    logic             w_n_last;
    logic [1:0]       w_slot;
    logic [N_W-1:0]   w_group;

    assign w_k_last = (r_k == K_LAST);
    assign w_n_last = (r_n == N_LAST);
    assign w_slot   = r_n[1:0];
    assign w_group  = r_n >> 2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort overrides every transition; a WRITE in progress still strobes this cycle.
    always_comb begin
        w_next         = r_state;
        o_mac_en       = 1'b0;
        o_mac_flush    = 1'b0;
        o_mac_valid    = 4'b0000;
        o_mac_bias_add = 1'b0;
        o_out_wr_en    = 1'b0;
        o_done         = 1'b0;
        o_busy         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_CLR;
            end
            S_CLR: begin
                o_mac_en    = 1'b1;
                o_mac_flush = 1'b1;
                w_next      = S_W_CLR;
            end
            S_W_CLR: begin
                if (i_mac_done) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_FEED;
            end
            S_FEED: begin
                o_mac_en    = 1'b1;
                o_mac_valid = w_k_last ? LAST_MASK : 4'b1111;
                w_next      = S_W_FEED;
            end
            S_W_FEED: begin
                if (i_mac_done) w_next = w_k_last ? S_CAPT : S_FETCH;
            end
            S_CAPT: begin
                w_next = (w_slot == 2'd3 || w_n_last) ? S_BFETCH : S_CLR;
            end
            S_BFETCH: begin
                w_next = S_BIAS;
            end
            S_BIAS: begin
                o_mac_en       = 1'b1;
                o_mac_bias_add = 1'b1;
                w_next         = S_W_BIAS;
            end
            S_W_BIAS: begin
                if (i_mac_done) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                o_out_wr_en = 1'b1;
                w_next      = w_n_last ? S_DONE : S_CLR;
            end
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_k       <= '0;
            r_n       <= '0;
            r_relu    <= 1'b0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_result2 <= '0;
            r_result3 <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_relu    <= i_relu_in;
                        r_k       <= '0;
                        r_n       <= '0;
                        r_result0 <= '0;
                        r_result1 <= '0;
                        r_result2 <= '0;
                        r_result3 <= '0;
                    end
                end
                S_W_CLR: begin
                    if (i_mac_done) r_k <= '0;
                end
                S_W_FEED: begin
                    if (i_mac_done && !w_k_last) r_k <= r_k + K_W'(1);
                end
                S_CAPT: begin
                    case (w_slot)
                        2'd0:    r_result0 <= i_mac_sum;
                        2'd1:    r_result1 <= i_mac_sum;
                        2'd2:    r_result2 <= i_mac_sum;
                        default: r_result3 <= i_mac_sum;
                    endcase
                    if (!(w_slot == 2'd3 || w_n_last)) r_n <= r_n + N_W'(1);
                end
                S_SETTLE: begin
                    r_wr_data <= i_mac_data;
                end
                S_WRITE: begin
                    if (!w_n_last) begin
                        r_n       <= r_n + N_W'(1);
                        r_result0 <= '0;
                        r_result1 <= '0;
                        r_result2 <= '0;
                        r_result3 <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address arithmetic is done at ADDR_W bits so it wraps rather than saturates.
    assign o_feat_addr   = ADDR_W'(r_k);
    assign o_wght_addr   = ADDR_W'(r_n) * ADDR_W'(IN_WORDS) + ADDR_W'(r_k);
    assign o_bias_addr   = ADDR_W'(w_group);
    assign o_out_wr_addr = ADDR_W'(w_group);
    assign o_out_wr_data = r_wr_data;
    assign o_mac_relu    = r_relu;
    assign o_result0     = r_result0;
    assign o_result1     = r_result1;
    assign o_result2     = r_result2;
    assign o_result3     = r_result3;

endmodule
